// File: rtl/sqrt_share_ctrl.sv
// Round-robin controller sharing one iterative square-root unit among NUM_REQ lanes.
// One operation in flight; results return to the issuing lane; hung units time out.
module sqrt_share_ctrl #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   input  logic [NUM_REQ-1:0]        rsp_ready,
   output logic [DATA_W-1:0]         sqrt_in,
   output logic                      sqrt_start,
   input  logic [DATA_W-1:0]         sqrt_result,
   input  logic                      sqrt_done,
   input  logic                      sqrt_available,
   output logic [2:0]                grant_id,
   output logic                      busy,
   output logic                      err_timeout
);

   localparam int unsigned IdxW = $clog2(NUM_REQ);
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYCLES - 1);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REQ - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e            state_q, state_d;
   logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IdxW-1:0]   grant_q, grant_d;
   logic [DATA_W-1:0] sqrt_in_q, sqrt_in_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              err_q, err_d;

   logic              win_found;
   logic [IdxW-1:0]   win_idx;
   logic [IdxW-1:0]   cand;
   logic [DATA_W-1:0] lane_data [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
      assign lane_data[g] = req_data[g*DATA_W +: DATA_W];
   end

   // First requesting lane at or after rr_ptr, wrapping.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = IdxW'((32'(rr_ptr_q) + i) % NUM_REQ);
         if (!win_found && req_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_d    = grant_q;
      sqrt_in_d  = sqrt_in_q;
      rsp_data_d = rsp_data_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      req_ready  = '0;
      rsp_valid  = '0;
      unique case (state_q)
         StIdle: begin
            if (sqrt_available && win_found) begin
               req_ready[win_idx] = 1'b1;
               sqrt_in_d          = lane_data[win_idx];
               grant_d            = win_idx;
               state_d            = StIssue;
            end
         end
         StIssue: begin
            cnt_d   = '0;
            state_d = StWait;
         end
         StWait: begin
            cnt_d = cnt_q + CntW'(1);
            // A completion on the limit cycle takes priority over the timeout.
            if (sqrt_done) begin
               rsp_data_d = sqrt_result;
               state_d    = StResp;
            end else if (cnt_q == CntMax) begin
               rsp_data_d = '1;
               err_d      = 1'b1;
               state_d    = StResp;
            end
         end
         StResp: begin
            rsp_valid[grant_q] = 1'b1;
            if (rsp_ready[grant_q]) begin
               rr_ptr_d = (grant_q == LastIdx) ? '0 : grant_q + IdxW'(1);
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= StIdle;
         rr_ptr_q   <= '0;
         grant_q    <= '0;
         sqrt_in_q  <= '0;
         rsp_data_q <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_q    <= grant_d;
         sqrt_in_q  <= sqrt_in_d;
         rsp_data_q <= rsp_data_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
      end
   end

   assign sqrt_in     = sqrt_in_q;
   assign rsp_data    = rsp_data_q;
   assign sqrt_start  = (state_q == StIssue);
   assign busy        = (state_q != StIdle);
   assign grant_id    = 3'(grant_q);
   assign err_timeout = err_q;

endmodule

// File: tb/tb_sqrt_share_ctrl.sv
// Directed bench for sqrt_share_ctrl: vector table of single operations plus
// hand-written sequences for arbitration, backpressure, timeout and reset.
module tb_sqrt_share_ctrl;

   logic          clk;
   logic          rstn;
   logic [3:0]    req_valid;
   logic [127:0]  req_data;
   logic [3:0]    req_ready;
   logic [3:0]    rsp_valid;
   logic [31:0]   rsp_data;
   logic [3:0]    rsp_ready;
   logic [31:0]   sqrt_in;
   logic          sqrt_start;
   logic [31:0]   sqrt_result;
   logic          sqrt_done;
   logic          sqrt_available;
   logic [2:0]    grant_id;
   logic          busy;
   logic          err_timeout;

   sqrt_share_ctrl #(
      .NUM_REQ        (4),
      .DATA_W         (32),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clk            (clk),
      .rstn           (rstn),
      .req_valid      (req_valid),
      .req_data       (req_data),
      .req_ready      (req_ready),
      .rsp_valid      (rsp_valid),
      .rsp_data       (rsp_data),
      .rsp_ready      (rsp_ready),
      .sqrt_in        (sqrt_in),
      .sqrt_start     (sqrt_start),
      .sqrt_result    (sqrt_result),
      .sqrt_done      (sqrt_done),
      .sqrt_available (sqrt_available),
      .grant_id       (grant_id),
      .busy           (busy),
      .err_timeout    (err_timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_data(input int lane, input logic [31:0] v);
      req_data[lane*32 +: 32] = v;
   endtask

   function automatic logic [31:0] isqrt(input logic [31:0] x);
      logic [31:0] r;
      logic [31:0] t;
      r = '0;
      for (int b = 15; b >= 0; b--) begin
         t = r | (32'd1 << b);
         if (64'(t) * 64'(t) <= 64'(x)) r = t;
      end
      return r;
   endfunction

   function automatic int onehot_idx(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   // Square-root unit model: done k cycles after the start cycle, or never when hung.
   int          model_delay = 1;
   bit          model_hang  = 1'b0;
   int          inj_cnt     = 0;
   initial begin
      int          rem;
      int          seen_inj;
      logic [31:0] op;
      rem = 0;
      seen_inj = 0;
      op = '0;
      sqrt_done = 1'b0;
      sqrt_result = 32'hDEAD_BEEF;
      forever begin
         tick();
         sqrt_done = 1'b0;
         sqrt_result = 32'hDEAD_BEEF;
         if (rem > 0) begin
            rem--;
            if (rem == 0) begin
               sqrt_done = 1'b1;
               sqrt_result = isqrt(op);
            end
         end
         if (sqrt_start) begin
            op = sqrt_in;
            rem = model_hang ? 0 : model_delay;
         end
         if (inj_cnt != seen_inj) begin
            seen_inj = inj_cnt;
            sqrt_done = 1'b1;
            sqrt_result = 32'h1234_5678;
         end
      end
   end

   // Handshake log sampled mid-cycle, away from both driving and the active edge.
   int          grant_log [$];
   int          res_lane  [$];
   logic [31:0] res_data  [$];
   initial begin
      forever begin
         @(negedge clk);
         if (req_ready != 4'b0) grant_log.push_back(onehot_idx(req_ready));
         if ((rsp_valid & rsp_ready) != 4'b0) begin
            res_lane.push_back(onehot_idx(rsp_valid & rsp_ready));
            res_data.push_back(rsp_data);
         end
      end
   end

   task automatic await_rsp(input int lane, input logic [31:0] exp, input string nm);
      logic [3:0] m;
      int n;
      m = 4'(1 << lane);
      n = 0;
      while ((rsp_valid & m) == 4'b0 && n < 200) begin
         tick();
         n++;
      end
      chk({nm, " rsp_valid"}, 64'(rsp_valid), 64'(m));
      chk({nm, " rsp_data"}, 64'(rsp_data), 64'(exp));
      rsp_ready = m;
      tick();
      rsp_ready = 4'b0;
      chk({nm, " rsp_valid after handshake"}, 64'(rsp_valid), 64'(0));
   endtask

   typedef struct {
      int          lane;
      logic [31:0] operand;
      int          delay;
      int          stall;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [7];

   initial begin
      logic [3:0] m;
      int         n;
      int         base_g;
      int         base_r;
      int         bad;

      vecs[0] = '{2, 32'd144,        16, 0, 32'd12};
      vecs[1] = '{0, 32'd1,          1,  0, 32'd1};
      vecs[2] = '{3, 32'd0,          1,  2, 32'd0};
      vecs[3] = '{1, 32'd1000000,    3,  1, 32'd1000};
      vecs[4] = '{2, 32'd49,         64, 0, 32'd7};
      vecs[5] = '{0, 32'hFFFF_FFFF,  63, 0, 32'd65535};
      vecs[6] = '{3, 32'd2,          2,  0, 32'd1};

      rstn = 1'b0;
      req_valid = '0;
      req_data = '0;
      rsp_ready = '0;
      sqrt_available = 1'b1;
      repeat (3) tick();
      chk("reset busy", 64'(busy), 64'(0));
      chk("reset req_ready", 64'(req_ready), 64'(0));
      chk("reset rsp_valid", 64'(rsp_valid), 64'(0));
      chk("reset sqrt_start", 64'(sqrt_start), 64'(0));
      chk("reset err_timeout", 64'(err_timeout), 64'(0));
      chk("reset grant_id", 64'(grant_id), 64'(0));
      chk("reset sqrt_in", 64'(sqrt_in), 64'(0));
      chk("reset rsp_data", 64'(rsp_data), 64'(0));
      rstn = 1'b1;
      tick();

      // Single operations from a table.
      for (int i = 0; i < 7; i++) begin
         m = 4'(1 << vecs[i].lane);
         model_delay = vecs[i].delay;
         set_data(vecs[i].lane, vecs[i].operand);
         req_valid = m;
         #1;
         chk($sformatf("v%0d req_ready", i), 64'(req_ready), 64'(m));
         chk($sformatf("v%0d idle busy", i), 64'(busy), 64'(0));
         tick();
         req_valid = '0;
         chk($sformatf("v%0d sqrt_start", i), 64'(sqrt_start), 64'(1));
         chk($sformatf("v%0d sqrt_in", i), 64'(sqrt_in), 64'(vecs[i].operand));
         chk($sformatf("v%0d grant_id", i), 64'(grant_id), 64'(vecs[i].lane));
         chk($sformatf("v%0d busy", i), 64'(busy), 64'(1));
         for (int c = 1; c <= vecs[i].delay; c++) begin
            tick();
            if (c == 1) chk($sformatf("v%0d start one cycle", i), 64'(sqrt_start), 64'(0));
            chk($sformatf("v%0d wait c%0d rsp_valid", i, c), 64'(rsp_valid), 64'(0));
         end
         tick();
         chk($sformatf("v%0d rsp_valid", i), 64'(rsp_valid), 64'(m));
         chk($sformatf("v%0d rsp_data", i), 64'(rsp_data), 64'(vecs[i].exp));
         rsp_ready = ~m;
         for (int s = 0; s < vecs[i].stall; s++) begin
            tick();
            chk($sformatf("v%0d stall%0d rsp_valid", i, s), 64'(rsp_valid), 64'(m));
            chk($sformatf("v%0d stall%0d rsp_data", i, s), 64'(rsp_data), 64'(vecs[i].exp));
         end
         rsp_ready = m;
         tick();
         rsp_ready = '0;
         chk($sformatf("v%0d rsp_valid cleared", i), 64'(rsp_valid), 64'(0));
         chk($sformatf("v%0d busy cleared", i), 64'(busy), 64'(0));
         chk($sformatf("v%0d err_timeout", i), 64'(err_timeout), 64'(0));
      end

      // All lanes requesting continuously: strict rotation 0,1,2,3,0,...
      base_g = grant_log.size();
      base_r = res_lane.size();
      model_delay = 2;
      for (int l = 0; l < 4; l++) set_data(l, 32'((l + 1) * (l + 1)));
      rsp_ready = 4'hF;
      req_valid = 4'hF;
      n = 0;
      while (res_lane.size() < base_r + 8 && n < 400) begin
         tick();
         n++;
      end
      req_valid = '0;
      rsp_ready = '0;
      tick();
      chk("rr result count", 64'(res_lane.size() - base_r), 64'(8));
      chk("rr grant count", 64'(grant_log.size() - base_g), 64'(8));
      for (int i = 0; i < 8; i++) begin
         if (base_g + i < grant_log.size())
            chk($sformatf("rr grant%0d", i), 64'(grant_log[base_g + i]), 64'(i % 4));
         if (base_r + i < res_lane.size()) begin
            chk($sformatf("rr res lane%0d", i), 64'(res_lane[base_r + i]), 64'(i % 4));
            chk($sformatf("rr res data%0d", i), 64'(res_data[base_r + i]), 64'((i % 4) + 1));
         end
      end
      chk("rr idle", 64'(busy), 64'(0));

      // Backpressure on lane 1 while lanes 0 and 2 wait; lane 2 is next.
      model_delay = 3;
      set_data(1, 32'd25);
      req_valid = 4'b0010;
      tick();
      req_valid = 4'b0101;
      set_data(0, 32'd200);
      set_data(2, 32'd36);
      n = 0;
      while (rsp_valid == 4'b0 && n < 50) begin
         tick();
         n++;
      end
      chk("bp rsp_valid", 64'(rsp_valid), 64'(4'b0010));
      chk("bp rsp_data", 64'(rsp_data), 64'(5));
      bad = 0;
      for (int s = 0; s < 10; s++) begin
         tick();
         if (rsp_valid != 4'b0010 || rsp_data != 32'd5 || req_ready != 4'b0 || sqrt_start)
            bad++;
      end
      chk("bp stall stable cycles", 64'(bad), 64'(0));
      chk("bp stall rsp_data", 64'(rsp_data), 64'(5));
      rsp_ready = 4'b0010;
      tick();
      rsp_ready = '0;
      chk("bp next grant lane2", 64'(req_ready), 64'(4'b0100));
      tick();
      req_valid = '0;
      chk("bp lane2 grant_id", 64'(grant_id), 64'(2));
      chk("bp lane2 sqrt_in", 64'(sqrt_in), 64'(36));
      await_rsp(2, 32'd6, "bp lane2");

      // Unit unavailable: nothing may be accepted; then rr_ptr (3) goes first.
      model_delay = 2;
      sqrt_available = 1'b0;
      set_data(0, 32'd64);
      set_data(3, 32'd100);
      req_valid = 4'b1001;
      bad = 0;
      for (int s = 0; s < 5; s++) begin
         #1;
         if (req_ready != 4'b0 || sqrt_start || busy) bad++;
         tick();
      end
      chk("unavail no activity", 64'(bad), 64'(0));
      sqrt_available = 1'b1;
      #1;
      chk("avail grant lane3", 64'(req_ready), 64'(4'b1000));
      tick();
      req_valid = 4'b0001;
      chk("avail lane3 grant_id", 64'(grant_id), 64'(3));
      await_rsp(3, 32'd10, "avail lane3");
      #1;
      chk("avail wrap to lane0", 64'(req_ready), 64'(4'b0001));
      tick();
      req_valid = '0;
      chk("avail lane0 grant_id", 64'(grant_id), 64'(0));
      await_rsp(0, 32'd8, "avail lane0");

      // Hung unit: exactly 64 WAIT cycles, then all-ones and the sticky flag.
      model_hang = 1'b1;
      set_data(1, 32'd77);
      req_valid = 4'b0010;
      tick();
      req_valid = '0;
      chk("to sqrt_start", 64'(sqrt_start), 64'(1));
      bad = 0;
      for (int c = 0; c < 64; c++) begin
         tick();
         if (rsp_valid != 4'b0 || !busy || err_timeout) bad++;
      end
      chk("to wait cycles clean", 64'(bad), 64'(0));
      tick();
      chk("to rsp_valid", 64'(rsp_valid), 64'(4'b0010));
      chk("to rsp_data", 64'(rsp_data), 64'(32'hFFFF_FFFF));
      chk("to err_timeout", 64'(err_timeout), 64'(1));
      rsp_ready = 4'b0010;
      tick();
      rsp_ready = '0;
      inj_cnt++;
      repeat (3) tick();
      chk("late done busy", 64'(busy), 64'(0));
      chk("late done rsp_valid", 64'(rsp_valid), 64'(0));
      chk("late done sqrt_start", 64'(sqrt_start), 64'(0));
      chk("err_timeout sticky", 64'(err_timeout), 64'(1));

      // Reset in the middle of WAIT.
      set_data(3, 32'd5);
      req_valid = 4'b1000;
      tick();
      req_valid = '0;
      repeat (5) tick();
      chk("mid-wait busy", 64'(busy), 64'(1));
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      chk("rst busy", 64'(busy), 64'(0));
      chk("rst rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst sqrt_start", 64'(sqrt_start), 64'(0));
      chk("rst err_timeout", 64'(err_timeout), 64'(0));
      chk("rst grant_id", 64'(grant_id), 64'(0));
      chk("rst sqrt_in", 64'(sqrt_in), 64'(0));
      chk("rst rsp_data", 64'(rsp_data), 64'(0));
      model_hang = 1'b0;
      model_delay = 2;
      set_data(0, 32'd81);
      set_data(2, 32'd9);
      req_valid = 4'b0101;
      #1;
      chk("rst rr_ptr zero", 64'(req_ready), 64'(4'b0001));
      tick();
      req_valid = '0;
      chk("rst lane0 sqrt_in", 64'(sqrt_in), 64'(81));
      await_rsp(0, 32'd9, "rst lane0");
      chk("rst final err_timeout", 64'(err_timeout), 64'(0));

      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
